// File: rtl/inst_mem_loader_if.sv
// Bundle shared between inst_mem_loader and its environment.
//
// Signals:
//   load_req_i / load_len_i          load request pulse and word count
//   byte_valid_i / byte_i            byte-serial program stream into the loader
//   byte_ready_o                     loader accepts a byte this cycle
//   mem_wr_en_o / mem_addr_o /
//   mem_data_o                       instruction memory port (byte address)
//
// Modports:
//   slave  - the loader (consumes requests and bytes, drives the memory port)
//   master - the environment (issues requests, supplies bytes, observes memory)
interface inst_mem_loader_if #(
    parameter int CPU_WIDTH = 32,
    parameter int LEN_WIDTH = 16
);
    logic                 load_req_i;
    logic [LEN_WIDTH-1:0] load_len_i;
    logic                 byte_valid_i;
    logic [7:0]           byte_i;
    logic                 byte_ready_o;
    logic                 mem_wr_en_o;
    logic [CPU_WIDTH-1:0] mem_addr_o;
    logic [CPU_WIDTH-1:0] mem_data_o;

    modport slave (
        input  load_req_i, load_len_i, byte_valid_i, byte_i,
        output byte_ready_o, mem_wr_en_o, mem_addr_o, mem_data_o
    );

    modport master (
        output load_req_i, load_len_i, byte_valid_i, byte_i,
        input  byte_ready_o, mem_wr_en_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory loader.
//
// Shares the instruction memory's single address port between the CPU fetch
// path and a byte-serial program loader. On an accepted load request the core
// is held, incoming bytes are packed little-endian into 32-bit words, and the
// words are written to consecutive word addresses starting at 0. Outside a
// load the block is transparent: the fetch PC drives the address and writes
// are disabled.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   bus          inst_mem_loader_if.slave (request, byte stream, memory port)
//   cpu_pc_i     core fetch byte address
//   cpu_hold_o   core must stall while high
//   load_busy_o  load in progress
//   load_done_o  one-cycle pulse when a load finishes
//   load_err_o   sticky: last request was longer than the memory
module inst_mem_loader #(
    parameter int CPU_WIDTH           = 32,
    parameter int INST_MEM_ADDR_DEPTH = 4096,
    parameter int LEN_WIDTH           = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inst_mem_loader_if.slave     bus,
    input  logic [CPU_WIDTH-1:0] cpu_pc_i,
    output logic                 cpu_hold_o,
    output logic                 load_busy_o,
    output logic                 load_done_o,
    output logic                 load_err_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(INST_MEM_ADDR_DEPTH);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [CPU_WIDTH-1:0] word_q, word_d;
    logic                 err_q, err_d;

    // Widen the requested length so the comparison against the depth is
    // independent of LEN_WIDTH.
    logic len_too_long;
    assign len_too_long = 32'(bus.load_len_i) > DEPTH_W;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        err_d      = err_q;

        case (state_q)
            RUN: begin
                if (bus.load_req_i) begin
                    if (len_too_long) begin
                        // Rejected: flag it and keep running the core.
                        err_d = 1'b1;
                    end else if (bus.load_len_i == '0) begin
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        err_d      = 1'b0;
                        len_d      = bus.load_len_i;
                        word_idx_d = '0;
                        byte_cnt_d = '0;
                        state_d    = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (bus.byte_valid_i) begin
                    // Lane 0 is the least significant byte.
                    word_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (word_idx_q == len_q - LEN_ONE) begin
                    state_d = DONE;
                end else begin
                    word_idx_d = word_idx_q + LEN_ONE;
                    state_d    = COLLECT;
                end
            end
            DONE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs are decodes of registered state; only the RUN-state address
    // path is a combinational pass-through of the fetch PC.
    assign bus.byte_ready_o = (state_q == COLLECT);
    assign bus.mem_wr_en_o  = (state_q == WRITE);
    assign bus.mem_data_o   = word_q;
    assign bus.mem_addr_o   = (state_q == RUN) ? cpu_pc_i
                                               : CPU_WIDTH'({word_idx_q, 2'b00});

    assign cpu_hold_o  = (state_q != RUN);
    assign load_busy_o = (state_q != RUN);
    assign load_done_o = (state_q == DONE);
    assign load_err_o  = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

    localparam int CPU_WIDTH = 32;
    localparam int DEPTH     = 4096;
    localparam int LEN_WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic [CPU_WIDTH-1:0] cpu_pc;
    logic cpu_hold, load_busy, load_done, load_err;

    inst_mem_loader_if #(.CPU_WIDTH(CPU_WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus();

    inst_mem_loader #(
        .CPU_WIDTH(CPU_WIDTH),
        .INST_MEM_ADDR_DEPTH(DEPTH),
        .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .cpu_pc_i(cpu_pc),
        .cpu_hold_o(cpu_hold),
        .load_busy_o(load_busy),
        .load_done_o(load_done),
        .load_err_o(load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural instruction memory: written on the clock edge ending a
    // write cycle, never cleared by reset.
    logic [31:0] tb_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (bus.mem_wr_en_o) tb_mem[bus.mem_addr_o[13:2]] <= bus.mem_data_o;
    end

    // Observed write log and done-pulse counter.
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int done_cnt = 0;
    always @(negedge clk) begin
        if (bus.mem_wr_en_o) begin
            obs_addr.push_back(bus.mem_addr_o);
            obs_data.push_back(bus.mem_data_o);
            check_val("ready_low_in_write", {63'd0, bus.byte_ready_o}, 64'd0);
        end
        if (load_done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one byte after an optional idle gap; returns at the negedge
    // following the edge on which it was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit inject);
        int waited;
        bus.byte_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
        bus.byte_valid_i = 1'b1;
        bus.byte_i = b;
        if (inject) begin
            bus.load_req_i = 1'b1;
            bus.load_len_i = 16'd5;
        end
        waited = 0;
        while (!bus.byte_ready_o && waited < 20) begin
            @(negedge clk);
            bus.load_req_i = 1'b0;
            waited++;
        end
        if (waited >= 20) check_val("byte_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        bus.load_req_i = 1'b0;
    endtask

    task automatic issue_req(input logic [15:0] len);
        @(negedge clk);
        bus.load_req_i = 1'b1;
        bus.load_len_i = len;
        @(negedge clk);
        bus.load_req_i = 1'b0;
        bus.load_len_i = 16'($urandom);
    endtask

    // Full load: request, stream bytes, check completion timing, the write
    // log against words packed from the byte list, and memory readback.
    task automatic do_load(input int len, input int max_gap, input bit fixed, input int inj_at);
        logic [7:0] bytes[$];
        logic [31:0] exp_word;
        int nw0, d0, gap;
        logic [7:0] fixed_bytes [0:7];
        fixed_bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < len * 4; i++)
            bytes.push_back(fixed ? fixed_bytes[i % 8] : 8'($urandom));
        nw0 = obs_addr.size();
        d0 = done_cnt;
        issue_req(16'(len));
        check_val("busy_after_req", {63'd0, load_busy}, 64'd1);
        check_val("hold_after_req", {63'd0, cpu_hold}, 64'd1);
        check_val("ready_after_req", {63'd0, bus.byte_ready_o}, 64'd1);
        check_val("err_cleared", {63'd0, load_err}, 64'd0);
        for (int i = 0; i < bytes.size(); i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            send_byte(bytes[i], gap, i == inj_at);
        end
        check_val("last_write_en", {63'd0, bus.mem_wr_en_o}, 64'd1);
        check_val("last_write_noready", {63'd0, bus.byte_ready_o}, 64'd0);
        @(negedge clk);
        check_val("done_pulse", {63'd0, load_done}, 64'd1);
        check_val("hold_in_done", {63'd0, cpu_hold}, 64'd1);
        check_val("no_write_in_done", {63'd0, bus.mem_wr_en_o}, 64'd0);
        @(negedge clk);
        check_val("hold_released", {63'd0, cpu_hold}, 64'd0);
        check_val("busy_released", {63'd0, load_busy}, 64'd0);
        check_val("done_one_cycle", {63'd0, load_done}, 64'd0);
        check_val("done_count", 64'(done_cnt - d0), 64'd1);
        check_val("write_count", 64'(obs_addr.size() - nw0), 64'(len));
        for (int k = 0; k < len; k++) begin
            exp_word = {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]};
            if (nw0 + k < obs_addr.size()) begin
                check_val("write_addr", 64'(obs_addr[nw0+k]), 64'(k * 4));
                check_val("write_data", 64'(obs_data[nw0+k]), 64'(exp_word));
            end
            cpu_pc = 32'(k * 4);
            #1;
            check_val("readback_addr", 64'(bus.mem_addr_o), 64'(k * 4));
            check_val("readback_data", 64'(tb_mem[k]), 64'(exp_word));
        end
        $display("load len=%0d max_gap=%0d inject=%0d writes=%0d", len, max_gap, inj_at, obs_addr.size() - nw0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, {63'd0, bus.byte_ready_o}, 64'd0);
        check_val({tag, "_hold"},  {63'd0, cpu_hold}, 64'd0);
        check_val({tag, "_busy"},  {63'd0, load_busy}, 64'd0);
        check_val({tag, "_done"},  {63'd0, load_done}, 64'd0);
        check_val({tag, "_err"},   {63'd0, load_err}, 64'd0);
        check_val({tag, "_wr_en"}, {63'd0, bus.mem_wr_en_o}, 64'd0);
        check_val({tag, "_data"},  64'(bus.mem_data_o), 64'd0);
        cpu_pc = $urandom & 32'hffff_fffc;
        #1;
        check_val({tag, "_addr"},  64'(bus.mem_addr_o), 64'(cpu_pc));
    endtask

    initial begin
        int nw0, d0;
        logic [7:0] rb [0:11];
        rst_n = 1'b0;
        bus.load_req_i = 1'b0;
        bus.load_len_i = '0;
        bus.byte_valid_i = 1'b0;
        bus.byte_i = '0;
        cpu_pc = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Program from the test plan, back-to-back, then with random gaps.
        do_load(2, 0, 1'b1, -1);
        do_load(2, 3, 1'b1, -1);

        // Zero-length request: done pulse next cycle, no write.
        nw0 = obs_addr.size();
        d0 = done_cnt;
        issue_req(16'd0);
        check_val("len0_done", {63'd0, load_done}, 64'd1);
        check_val("len0_hold", {63'd0, cpu_hold}, 64'd1);
        @(negedge clk);
        check_val("len0_hold_end", {63'd0, cpu_hold}, 64'd0);
        check_val("len0_done_end", {63'd0, load_done}, 64'd0);
        check_val("len0_writes", 64'(obs_addr.size() - nw0), 64'd0);
        check_val("len0_done_count", 64'(done_cnt - d0), 64'd1);
        $display("load len=0 done");

        // Oversized request is rejected; the next valid one clears the flag.
        nw0 = obs_addr.size();
        issue_req(16'(DEPTH + 1));
        check_val("err_set", {63'd0, load_err}, 64'd1);
        check_val("err_no_hold", {63'd0, cpu_hold}, 64'd0);
        check_val("err_no_busy", {63'd0, load_busy}, 64'd0);
        repeat (3) @(negedge clk);
        check_val("err_sticky", {63'd0, load_err}, 64'd1);
        check_val("err_no_write", 64'(obs_addr.size() - nw0), 64'd0);
        $display("load len=%0d rejected", DEPTH + 1);
        do_load(1, 2, 1'b0, -1);

        // Request while busy must be ignored.
        do_load(2, 1, 1'b1, 3);

        // Random loads.
        for (int n = 0; n < 4; n++)
            do_load(int'($urandom_range(1, 4)), 3, 1'b0, -1);

        // Reset after the 6th byte of a 3-word load.
        for (int i = 0; i < 12; i++) rb[i] = 8'($urandom);
        nw0 = obs_addr.size();
        d0 = done_cnt;
        issue_req(16'd3);
        for (int i = 0; i < 6; i++) send_byte(rb[i], int'($urandom_range(0, 2)), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        check_val("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        check_val("midrst_writes", 64'(obs_addr.size() - nw0), 64'd1);
        check_val("midrst_word0", 64'(tb_mem[0]), 64'({rb[3], rb[2], rb[1], rb[0]}));
        check_val("midrst_busy", {63'd0, load_busy}, 64'd0);
        $display("load len=3 interrupted by reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
